// File: rtl/mult_pkg.sv
// Shared types and default sizing for the multiplier product accumulator.
package mult_pkg;

    localparam int N_DEF     = 16;
    localparam int GUARD_DEF = 8;
    localparam int CNT_W_DEF = 8;

    typedef enum logic {ACCUM, DONE} acc_state_e;

    function automatic int acc_width(input int n, input int guard);
        return 2 * n + guard;
    endfunction

endpackage

// File: rtl/mult_acc_adder.sv
// Combinational W-bit unsigned adder with carry-out.
// MULT_ACCUMULATOR_SAT_EN clamps the sum to all-ones whenever the add carries out.
module mult_acc_adder #(
    parameter int W = 40
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] raw;

    assign raw  = {1'b0, a} + {1'b0, b};
    assign cout = raw[W];

`ifdef MULT_ACCUMULATOR_SAT_EN
    // Once clamped, later adds carry out again, so the clamp is sticky for the burst
    assign sum = cout ? '1 : raw[W-1:0];
`else
    assign sum = raw[W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Burst accumulator for the 2N-bit product bus: sums beats until s_last, then
// holds the result on a valid/ready output. Optional saturation via MULT_ACCUMULATOR_SAT_EN.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int  N     = N_DEF,
    parameter int  GUARD = GUARD_DEF,
    parameter int  CNT_W = CNT_W_DEF,
    localparam int ACC_W = acc_width(N, GUARD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [2*N-1:0]   s_prod,
    input  logic             s_last,
    input  logic             clr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_acc,
    output logic [CNT_W-1:0] m_count,
    output logic             m_ovf
);

    acc_state_e       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             beat;
    logic [ACC_W-1:0] base_acc, sum_nxt;
    logic [CNT_W-1:0] base_cnt, cnt_nxt;
    logic             base_ovf, ovf_nxt, cout;

    assign s_ready = rst_n && (state == ACCUM);
    assign beat    = s_valid && s_ready;

    // clr in the same cycle as a beat restarts the burst with that beat
    assign base_acc = clr ? '0 : acc;
    assign base_cnt = clr ? '0 : count;
    assign base_ovf = clr ? 1'b0 : ovf;

    mult_acc_adder #(.W(ACC_W)) u_add (
        .a    (base_acc),
        .b    (ACC_W'(s_prod)),
        .sum  (sum_nxt),
        .cout (cout)
    );

    assign cnt_nxt = (&base_cnt) ? base_cnt : base_cnt + 1'b1;
    assign ovf_nxt = base_ovf | cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            m_valid <= 1'b0;
            m_acc   <= '0;
            m_count <= '0;
            m_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        acc   <= sum_nxt;
                        count <= cnt_nxt;
                        ovf   <= ovf_nxt;
                        if (s_last) begin
                            m_acc   <= sum_nxt;
                            m_count <= cnt_nxt;
                            m_ovf   <= ovf_nxt;
                            m_valid <= 1'b1;
                            state   <= DONE;
                        end
                    end else if (clr) begin
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                DONE: begin
                    // clr discards the result; m_ready consumes it; both reopen the input
                    if (clr || m_ready) begin
                        m_valid <= 1'b0;
                        acc     <= '0;
                        count   <= '0;
                        ovf     <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed and randomized-backpressure checks for mult_accumulator.
module tb_mult_accumulator;

    localparam int ACC_W = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_last, clr, m_ready;
    logic        s_ready, m_valid, m_ovf;
    logic [31:0] s_prod;
    logic [ACC_W-1:0] m_acc;
    logic [7:0]  m_count;

    // GUARD=0 instance for carry-out / saturation behaviour
    logic        g_valid, g_last, g_clr, g_m_ready;
    logic        g_ready, g_m_valid, g_m_ovf;
    logic [31:0] g_prod, g_m_acc;
    logic [7:0]  g_m_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_accumulator #(.N(16), .GUARD(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_prod(s_prod), .s_last(s_last), .clr(clr), .m_valid(m_valid),
        .m_ready(m_ready), .m_acc(m_acc), .m_count(m_count), .m_ovf(m_ovf)
    );

    mult_accumulator #(.N(16), .GUARD(0), .CNT_W(8)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .s_valid(g_valid), .s_ready(g_ready),
        .s_prod(g_prod), .s_last(g_last), .clr(g_clr), .m_valid(g_m_valid),
        .m_ready(g_m_ready), .m_acc(g_m_acc), .m_count(g_m_count), .m_ovf(g_m_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a beat at a negedge, wait (bounded) for s_ready, return at the negedge after acceptance
    task automatic send_beat(input logic [31:0] prod, input logic last);
        int waited;
        s_valid = 1'b1;
        s_prod  = prod;
        s_last  = last;
        waited  = 0;
        while (!s_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed s_ready=0 expected s_ready=1 within 1000 cycles");
        end
        @(negedge clk);
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_acc"},   64'(m_acc),   64'd0);
        check({tag, "_m_count"}, 64'(m_count), 64'd0);
        check({tag, "_m_ovf"},   64'(m_ovf),   64'd0);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    endtask

    initial begin
        logic [63:0] ref_sum;
        logic [39:0] exp_acc;
        logic        exp_ovf;
        int          len;

        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_prod = '0; clr = 1'b0; m_ready = 1'b0;
        g_valid = 1'b0; g_last = 1'b0; g_prod = '0; g_clr = 1'b0; g_m_ready = 1'b0;

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(s_ready), 64'd1);

        // 4-beat burst of 0xFFFE0001
        for (int i = 0; i < 4; i++) begin
            send_beat(32'hFFFE0001, i == 3);
            if (i == 2) check("no_early_valid", 64'(m_valid), 64'd0);
        end
        s_valid = 1'b0;
        check("b4_m_valid", 64'(m_valid), 64'd1);
        check("b4_m_acc",   64'(m_acc),   64'h3FFF80004);
        check("b4_m_count", 64'(m_count), 64'd4);
        check("b4_m_ovf",   64'(m_ovf),   64'd0);
        check("b4_s_ready", 64'(s_ready), 64'd0);
        consume();
        check("b4_consumed", 64'(m_valid), 64'd0);
        check("b4_ready_back", 64'(s_ready), 64'd1);

        // Single beat, held under backpressure
        send_beat(32'h12345678, 1'b1);
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_m_valid", 64'(m_valid), 64'd1);
            check("hold_m_acc",   64'(m_acc),   64'h12345678);
            check("hold_m_count", 64'(m_count), 64'd1);
            check("hold_s_ready", 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        // clr in DONE discards the result even with m_ready high
        clr = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; m_ready = 1'b0;
        check("clr_done_m_valid", 64'(m_valid), 64'd0);
        check("clr_done_s_ready", 64'(s_ready), 64'd1);
        send_beat(32'd5, 1'b1);
        s_valid = 1'b0;
        check("after_clr_acc",   64'(m_acc),   64'd5);
        check("after_clr_count", 64'(m_count), 64'd1);
        consume();

        // clr with the last beat: 10, 20, then clr + 30 last
        send_beat(32'd10, 1'b0);
        send_beat(32'd20, 1'b0);
        clr = 1'b1;
        send_beat(32'd30, 1'b1);
        clr = 1'b0; s_valid = 1'b0;
        check("clr_beat_valid", 64'(m_valid), 64'd1);
        check("clr_beat_acc",   64'(m_acc),   64'd30);
        check("clr_beat_count", 64'(m_count), 64'd1);
        consume();

        // clr with no beat clears partial sum
        send_beat(32'd7, 1'b0);
        send_beat(32'd8, 1'b0);
        s_valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        send_beat(32'd9, 1'b1);
        s_valid = 1'b0;
        check("clr_idle_acc",   64'(m_acc),   64'd9);
        check("clr_idle_count", 64'(m_count), 64'd1);
        check("clr_idle_ovf",   64'(m_ovf),   64'd0);
        consume();

        // GUARD=0: two beats of all-ones carry out of 32 bits
        g_valid = 1'b1; g_prod = 32'hFFFFFFFF; g_last = 1'b0;
        @(negedge clk);
        g_last = 1'b1;
        @(negedge clk);
        g_valid = 1'b0; g_last = 1'b0;
        check("g0_m_valid", 64'(g_m_valid), 64'd1);
`ifdef MULT_ACCUMULATOR_SAT_EN
        check("g0_m_acc", 64'(g_m_acc), 64'hFFFFFFFF);
`else
        check("g0_m_acc", 64'(g_m_acc), 64'hFFFFFFFE);
`endif
        check("g0_m_ovf",   64'(g_m_ovf),   64'd1);
        check("g0_m_count", 64'(g_m_count), 64'd2);
        g_m_ready = 1'b1;
        @(negedge clk);
        g_m_ready = 1'b0;

        // Random bursts with input gaps and output backpressure
        for (int b = 0; b < 100; b++) begin
            len = int'($urandom_range(1, 300));
            ref_sum = '0;
            for (int i = 0; i < len; i++) begin
                logic [31:0] p;
                p = $urandom;
                ref_sum = ref_sum + 64'(p);
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    @(negedge clk);
                end
                send_beat(p, i == len - 1);
            end
            s_valid = 1'b0;
            exp_ovf = (ref_sum[63:40] != 0);
`ifdef MULT_ACCUMULATOR_SAT_EN
            exp_acc = exp_ovf ? 40'hFF_FFFF_FFFF : ref_sum[39:0];
`else
            exp_acc = ref_sum[39:0];
`endif
            check("rnd_m_valid", 64'(m_valid), 64'd1);
            check("rnd_m_acc",   64'(m_acc),   64'(exp_acc));
            check("rnd_m_count", 64'(m_count), 64'((len > 255) ? 255 : len));
            check("rnd_m_ovf",   64'(m_ovf),   64'(exp_ovf));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume();
        end

        // Async reset mid-burst (m_acc still holds the last random result)
        send_beat(32'd100, 1'b0);
        send_beat(32'd200, 1'b0);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(32'd1, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd3, 1'b1);
        s_valid = 1'b0;
        check("post_rst_acc",   64'(m_acc),   64'd6);
        check("post_rst_count", 64'(m_count), 64'd3);

        // Async reset while DONE
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("rst_done");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(32'd4, 1'b1);
        s_valid = 1'b0;
        check("post_rst2_acc",   64'(m_acc),   64'd4);
        check("post_rst2_count", 64'(m_count), 64'd1);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Downstream consumer of the 2N-bit unsigned product bus from the multiplier datapath. Accepts one product per cycle over a valid/ready handshake and sums a burst of products into a guarded accumulator. A burst is delimited by a last flag. Presents the final sum and beat count on a registered valid/ready output, enabling dot-product and MAC use of the multiplier.

Parameters:
N, 16, operand width of the upstream multiplier; product width is 2*N
GUARD, 8, extra accumulator MSBs; ACC_W = 2*N + GUARD
CNT_W, 8, width of the beat counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  product beat valid
s_ready  output  1  block can accept a beat
s_prod  input  2*N  unsigned product
s_last  input  1  beat is the last of the burst
clr  input  1  synchronous abort/clear of the current burst
m_valid  output  1  result valid
m_ready  input  1  downstream accepts result
m_acc  output  ACC_W  burst sum
m_count  output  CNT_W  number of beats in burst
m_ovf  output  1  sum exceeded ACC_W bits during burst

Behaviour:
- Reset (async assert, sync release in clk domain): state=ACCUM, acc=0, count=0, ovf=0, m_valid=0, m_acc=0, m_count=0, m_ovf=0.
- s_ready=1 while rst_n=1 and state=ACCUM; otherwise 0. s_ready is purely a function of state.
- FSM has two states, ACCUM and DONE.
- ACCUM, beat accepted (s_valid & s_ready):
  - acc <= acc + zero-extended s_prod.
  - count <= count+1, saturating at 2^CNT_W-1.
  - ovf |= carry out of ACC_W.
- ACCUM, beat accepted with s_last=1:
  - The same add is performed.
  - m_acc/m_count/m_ovf load the post-add values; m_valid=1 next cycle; state->DONE.
  - Latency is last beat accepted at cycle t -> m_valid at t+1.
- DONE:
  - m_acc/m_count/m_ovf held stable while m_valid & ~m_ready.
  - On m_valid & m_ready: m_valid->0, acc/count/ovf->0, state->ACCUM. s_ready rises the following cycle; there is no same-cycle bypass.
- Single-beat burst (s_last on first beat): m_count=1, m_acc=s_prod.
- clr in ACCUM without an accepted beat: acc/count/ovf->0.
- clr in ACCUM with an accepted beat in the same cycle: clear first, then add. acc=s_prod, count=1, ovf=0. If s_last=1, it completes as a 1-beat burst.
- clr in DONE: m_valid->0, result discarded, accumulator cleared, state->ACCUM. clr has priority over m_ready.
- s_prod/s_last are ignored when s_valid=0. s_valid is not required to stay asserted while s_ready=0.
- Reset mid-burst or in DONE: immediate return to reset values; partial result is lost.
- Counter overflow: count saturates and never wraps; the accumulator is unaffected.

Optional Feature:
- Macro MULT_ACCUMULATOR_SAT_EN.
- Defined: on any add that carries out of ACC_W, acc clamps to all-ones and stays there for the rest of the burst; m_ovf reports the event.
- Undefined: acc wraps modulo 2^ACC_W; m_ovf still reports the sticky carry.

Decomposition:
- Shared package mult_pkg holds:
  - default N/GUARD/CNT_W localparams
  - acc_state_e enum {ACCUM, DONE}
  - function acc_width(N, GUARD) returning 2*N+GUARD
- One natural sub-module: mult_acc_adder, the combinational ACC_W adder with carry-out and optional saturation under the macro. It is reusable by a future signed MAC.
- The FSM, counter and output registers stay in mult_accumulator.

Test Plan:
- N=16: 4-beat burst of 0xFFFE0001 each, last on beat 4 -> m_valid 1 cycle later, m_acc=0x3FFF80004, m_count=4, m_ovf=0.
- Single beat s_prod=0x12345678 with s_last -> m_acc=0x12345678, m_count=1. Hold m_ready=0 for 5 cycles -> outputs stable, s_ready=0 throughout.
- GUARD=0, two beats of 0xFFFFFFFF -> without macro: m_acc=0xFFFFFFFE, m_ovf=1; with MULT_ACCUMULATOR_SAT_EN: m_acc=0xFFFFFFFF, m_ovf=1.
- Burst of 3 beats (values 10, 20, 30), clr with beat 3 (30, last) -> m_acc=30, m_count=1.
- Randomized s_valid/m_ready backpressure, 100 bursts of random length 1..300 with CNT_W=8 -> sums match reference model; m_count saturates at 255 for lengths >255.
- rst_n asserted asynchronously mid-burst and while DONE -> all outputs 0 immediately. First burst after release produces the correct sum from zero.
